// File: rtl/vid_frame_pkg.sv
// Shared types for the triple-buffer frame scheduler: slot indices, arbiter
// states and requester sides.
package vid_frame_pkg;
    localparam int SLOT_CNT = 3;
    localparam int SLOT_W   = $clog2(SLOT_CNT);

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [1:0] {IDLE, CMD, BUSY} state_t;
    typedef enum logic {SIDE_WR, SIDE_RD} side_t;
endpackage

// File: rtl/frame_slot_mgr.sv
// Triple-buffer slot bookkeeping: latches frame starts, rotates the slot
// permutation in IDLE and counts dropped and repeated frames.
module frame_slot_mgr
    import vid_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_fs,
    input  logic       i_rd_fs,
    input  logic       i_idle,
    input  logic       i_wr_dirty,
    output slot_t      o_wr_slot,
    output slot_t      o_rd_slot,
    output logic       o_wr_pend,
    output logic       o_rd_pend,
    output logic [7:0] o_drop_cnt,
    output logic [7:0] o_rep_cnt
);
    slot_t      r_wr_slot, r_rd_slot, r_spare;
    logic       r_fresh, r_wr_pend, r_rd_pend;
    logic [7:0] r_drop_cnt, r_rep_cnt;

    logic  w_apply, w_fr1, w_fr2, w_drop, w_rep;
    slot_t w_wr1, w_sp1, w_rd2, w_sp2;

    assign w_apply = i_idle & (r_wr_pend | r_rd_pend);

    // Write swap is resolved first so a simultaneous read swap picks up the
    // frame that just completed.
    always_comb begin
        w_wr1  = r_wr_slot;
        w_sp1  = r_spare;
        w_fr1  = r_fresh;
        w_drop = 1'b0;
        if (r_wr_pend && i_wr_dirty) begin
            w_wr1  = r_spare;
            w_sp1  = r_wr_slot;
            w_fr1  = 1'b1;
            w_drop = r_fresh;
        end
        w_rd2 = r_rd_slot;
        w_sp2 = w_sp1;
        w_fr2 = w_fr1;
        w_rep = 1'b0;
        if (r_rd_pend) begin
            if (w_fr1) begin
                w_rd2 = w_sp1;
                w_sp2 = r_rd_slot;
                w_fr2 = 1'b0;
            end else begin
                w_rep = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_slot  <= slot_t'(0);
            r_rd_slot  <= slot_t'(1);
            r_spare    <= slot_t'(2);
            r_fresh    <= 1'b0;
            r_wr_pend  <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_drop_cnt <= '0;
            r_rep_cnt  <= '0;
        end else begin
            // A pulse landing on the consuming cycle starts a new pending frame.
            r_wr_pend <= i_wr_fs | (r_wr_pend & ~w_apply);
            r_rd_pend <= i_rd_fs | (r_rd_pend & ~w_apply);
            if (w_apply) begin
                r_wr_slot <= w_wr1;
                r_rd_slot <= w_rd2;
                r_spare   <= w_sp2;
                r_fresh   <= w_fr2;
                if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
                if (w_rep && r_rep_cnt != 8'hFF)   r_rep_cnt  <= r_rep_cnt + 8'd1;
            end
        end
    end

    assign o_wr_slot  = r_wr_slot;
    assign o_rd_slot  = r_rd_slot;
    assign o_wr_pend  = r_wr_pend;
    assign o_rd_pend  = r_rd_pend;
    assign o_drop_cnt = r_drop_cnt;
    assign o_rep_cnt  = r_rep_cnt;
endmodule

// File: rtl/vid_frame_sched.sv
// Triple-buffer frame scheduler and DDR burst arbiter: one command port shared
// between the write FIFO and the read FIFO, addresses derived from slot + pointer.
module vid_frame_sched
    import vid_frame_pkg::*;
#(
    parameter int          ADDR_W       = 29,
    parameter int unsigned FRAME_BASE   = 0,
    parameter int unsigned FRAME_STRIDE = 32'h0020_0000,
    parameter int unsigned FRAME_SIZE   = 1843200,
    parameter int unsigned BURST_SIZE   = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_fs,
    input  logic              i_rd_fs,
    input  logic              i_wr_req,
    input  logic              i_rd_req,
    input  logic              i_rd_urgent,
    output logic              o_mem_cmd_valid,
    input  logic              i_mem_cmd_ready,
    output logic              o_mem_cmd_we,
    output logic [ADDR_W-1:0] o_mem_cmd_addr,
    input  logic              i_mem_done,
    output logic              o_wr_gnt,
    output logic              o_rd_gnt,
    output slot_t             o_wr_slot,
    output slot_t             o_rd_slot,
    output logic [7:0]        o_drop_cnt,
    output logic [7:0]        o_rep_cnt
);
    localparam int PTR_W = $clog2(FRAME_SIZE + 1);

    state_t            r_state;
    side_t             r_last;
    logic              r_cmd_valid, r_cmd_we, r_wr_gnt, r_rd_gnt;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic              r_wr_full, r_rd_full, r_wr_dirty;

    slot_t             w_wr_slot, w_rd_slot;
    logic              w_wr_pend, w_rd_pend, w_wr_elig, w_rd_elig;
    side_t             w_pick;
    logic [PTR_W-1:0]  w_wr_nxt, w_rd_nxt;

    function automatic logic [ADDR_W-1:0] slot_addr(input slot_t s, input logic [PTR_W-1:0] p);
        return ADDR_W'(FRAME_BASE) + ADDR_W'(s) * ADDR_W'(FRAME_STRIDE) + ADDR_W'(p);
    endfunction

    frame_slot_mgr u_slot_mgr (
        .clk        (clk),
        .rst        (rst),
        .i_wr_fs    (i_wr_fs),
        .i_rd_fs    (i_rd_fs),
        .i_idle     (r_state == IDLE),
        .i_wr_dirty (r_wr_dirty),
        .o_wr_slot  (w_wr_slot),
        .o_rd_slot  (w_rd_slot),
        .o_wr_pend  (w_wr_pend),
        .o_rd_pend  (w_rd_pend),
        .o_drop_cnt (o_drop_cnt),
        .o_rep_cnt  (o_rep_cnt)
    );

    assign w_wr_elig = i_wr_req & ~r_wr_full;
    assign w_rd_elig = i_rd_req & ~r_rd_full;
    assign w_wr_nxt  = r_wr_ptr + PTR_W'(BURST_SIZE);
    assign w_rd_nxt  = r_rd_ptr + PTR_W'(BURST_SIZE);

    // Urgent read preempts; otherwise alternate against the last granted side.
    always_comb begin
        w_pick = SIDE_WR;
        if (w_rd_elig && (i_rd_urgent || !w_wr_elig || r_last == SIDE_WR))
            w_pick = SIDE_RD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= SIDE_RD;
            r_cmd_valid <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_wr_gnt    <= 1'b0;
            r_rd_gnt    <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wr_full   <= 1'b0;
            r_rd_full   <= 1'b0;
            r_wr_dirty  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wr_pend || w_rd_pend) begin
                        if (w_wr_pend) begin
                            r_wr_ptr   <= '0;
                            r_wr_full  <= 1'b0;
                            r_wr_dirty <= 1'b0;
                        end
                        if (w_rd_pend) begin
                            r_rd_ptr  <= '0;
                            r_rd_full <= 1'b0;
                        end
                    end else if (w_wr_elig || w_rd_elig) begin
                        r_last      <= w_pick;
                        r_cmd_valid <= 1'b1;
                        r_cmd_we    <= (w_pick == SIDE_WR);
                        r_cmd_addr  <= (w_pick == SIDE_WR) ? slot_addr(w_wr_slot, r_wr_ptr)
                                                           : slot_addr(w_rd_slot, r_rd_ptr);
                        r_state     <= CMD;
                    end
                end
                CMD: begin
                    if (i_mem_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_wr_gnt    <= (r_last == SIDE_WR);
                        r_rd_gnt    <= (r_last == SIDE_RD);
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_mem_done) begin
                        r_wr_gnt <= 1'b0;
                        r_rd_gnt <= 1'b0;
                        if (r_last == SIDE_WR) begin
                            r_wr_dirty <= 1'b1;
                            if (w_wr_nxt == PTR_W'(FRAME_SIZE)) begin
                                r_wr_ptr  <= '0;
                                r_wr_full <= 1'b1;
                            end else begin
                                r_wr_ptr <= w_wr_nxt;
                            end
                        end else begin
                            if (w_rd_nxt == PTR_W'(FRAME_SIZE)) begin
                                r_rd_ptr  <= '0;
                                r_rd_full <= 1'b1;
                            end else begin
                                r_rd_ptr <= w_rd_nxt;
                            end
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_cmd_valid = r_cmd_valid;
    assign o_mem_cmd_we    = r_cmd_we;
    assign o_mem_cmd_addr  = r_cmd_addr;
    assign o_wr_gnt        = r_wr_gnt;
    assign o_rd_gnt        = r_rd_gnt;
    assign o_wr_slot       = w_wr_slot;
    assign o_rd_slot       = w_rd_slot;
endmodule

// File: tb/tb_vid_frame_sched.sv
// Directed bench for vid_frame_sched with 4 bursts per frame; the memory
// controller is modelled by a burst handshake task.
module tb_vid_frame_sched;
    import vid_frame_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_wr_fs = 0, i_rd_fs = 0, i_wr_req = 0, i_rd_req = 0, i_rd_urgent = 0;
    logic        i_mem_cmd_ready = 0, i_mem_done = 0;
    logic        o_mem_cmd_valid, o_mem_cmd_we, o_wr_gnt, o_rd_gnt;
    logic [28:0] o_mem_cmd_addr;
    slot_t       o_wr_slot, o_rd_slot;
    logic [7:0]  o_drop_cnt, o_rep_cnt;

    int n_chk = 0;
    int n_pass = 0;

    vid_frame_sched #(.FRAME_SIZE(2048), .BURST_SIZE(512)) dut (
        .clk(clk), .rst(rst),
        .i_wr_fs(i_wr_fs), .i_rd_fs(i_rd_fs),
        .i_wr_req(i_wr_req), .i_rd_req(i_rd_req), .i_rd_urgent(i_rd_urgent),
        .o_mem_cmd_valid(o_mem_cmd_valid), .i_mem_cmd_ready(i_mem_cmd_ready),
        .o_mem_cmd_we(o_mem_cmd_we), .o_mem_cmd_addr(o_mem_cmd_addr),
        .i_mem_done(i_mem_done), .o_wr_gnt(o_wr_gnt), .o_rd_gnt(o_rd_gnt),
        .o_wr_slot(o_wr_slot), .o_rd_slot(o_rd_slot),
        .o_drop_cnt(o_drop_cnt), .o_rep_cnt(o_rep_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_fs(input logic w, input logic r);
        i_wr_fs = w;
        i_rd_fs = r;
        tick(1);
        i_wr_fs = 0;
        i_rd_fs = 0;
    endtask

    // One full command/burst handshake; fs_both fires both frame starts mid-burst.
    task automatic burst(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                         input logic fs_both);
        int n = 0;
        while (!o_mem_cmd_valid && n < 20) begin
            tick(1);
            n++;
        end
        chk({tag, ".valid"}, {31'd0, o_mem_cmd_valid}, 1);
        chk({tag, ".we"}, {31'd0, o_mem_cmd_we}, {31'd0, exp_we});
        chk({tag, ".addr"}, {3'd0, o_mem_cmd_addr}, exp_addr);
        i_mem_cmd_ready = 1;
        tick(1);
        i_mem_cmd_ready = 0;
        chk({tag, ".gnt"}, {30'd0, o_wr_gnt, o_rd_gnt}, exp_we ? 32'd2 : 32'd1);
        if (fs_both) pulse_fs(1, 1);
        i_mem_done = 1;
        tick(1);
        i_mem_done = 0;
    endtask

    initial begin
        tick(2);
        rst = 0;
        chk("rst.valid", {31'd0, o_mem_cmd_valid}, 0);
        chk("rst.gnt", {30'd0, o_wr_gnt, o_rd_gnt}, 0);
        chk("rst.wr_slot", {30'd0, o_wr_slot}, 0);
        chk("rst.rd_slot", {30'd0, o_rd_slot}, 1);
        chk("rst.cnts", {16'd0, o_drop_cnt, o_rep_cnt}, 0);

        // Write path: no dirty data yet, so the frame start keeps slot 0
        pulse_fs(1, 0);
        i_wr_req = 1;
        for (int i = 0; i < 4; i++) burst("wr_path", 1, 32'h200 * i, 0);
        tick(4);
        chk("wr_full_block", {31'd0, o_mem_cmd_valid}, 0);
        chk("wr_path.slot", {30'd0, o_wr_slot}, 0);

        // Read swap of the completed frame
        i_wr_req = 0;
        pulse_fs(1, 0);
        tick(2);
        chk("wswap.wr_slot", {30'd0, o_wr_slot}, 2);
        pulse_fs(0, 1);
        tick(2);
        chk("rswap.rd_slot", {30'd0, o_rd_slot}, 0);
        i_rd_req = 1;
        burst("rswap_cmd", 0, 32'h0, 0);
        i_rd_req = 0;
        chk("rswap.rep", {24'd0, o_rep_cnt}, 0);

        // Two frames written with no read frame start between them
        i_wr_req = 1;
        for (int i = 0; i < 4; i++) burst("drop_f1", 1, 32'h400000 + 32'h200 * i, 0);
        i_wr_req = 0;
        pulse_fs(1, 0);
        tick(2);
        chk("drop.wr_slot1", {30'd0, o_wr_slot}, 1);
        i_wr_req = 1;
        for (int i = 0; i < 4; i++) burst("drop_f2", 1, 32'h200000 + 32'h200 * i, 0);
        i_wr_req = 0;
        pulse_fs(1, 0);
        tick(2);
        chk("drop.cnt", {24'd0, o_drop_cnt}, 1);
        chk("drop.rd_slot", {30'd0, o_rd_slot}, 0);
        chk("drop.wr_slot2", {30'd0, o_wr_slot}, 2);

        // Repeat on a read frame start with nothing fresh
        rst = 1;
        tick(1);
        rst = 0;
        chk("rst2.cnts", {16'd0, o_drop_cnt, o_rep_cnt}, 0);
        pulse_fs(0, 1);
        tick(2);
        chk("rep.cnt", {24'd0, o_rep_cnt}, 1);
        chk("rep.rd_slot", {30'd0, o_rd_slot}, 1);

        // Both frame starts during a write burst
        i_wr_req = 1;
        burst("sim_wr", 1, 32'h0, 1);
        tick(1);
        chk("sim.rd_slot", {30'd0, o_rd_slot}, 0);
        chk("sim.wr_slot", {30'd0, o_wr_slot}, 2);
        chk("sim.rep", {24'd0, o_rep_cnt}, 1);
        burst("sim_next", 1, 32'h400000, 0);
        i_wr_req = 0;

        // Arbitration: round-robin, then urgent reads, then reset mid-CMD
        rst = 1;
        tick(1);
        rst = 0;
        i_wr_req = 1;
        i_rd_req = 1;
        burst("rr_w0", 1, 32'h0, 0);
        burst("rr_r0", 0, 32'h200000, 0);
        burst("rr_w1", 1, 32'h200, 0);
        burst("rr_r1", 0, 32'h200200, 0);
        i_rd_urgent = 1;
        burst("urg_r2", 0, 32'h200400, 0);
        burst("urg_r3", 0, 32'h200600, 0);
        i_rd_urgent = 0;
        begin
            int n = 0;
            while (!o_mem_cmd_valid && n < 20) begin
                tick(1);
                n++;
            end
        end
        chk("rstcmd.addr", {3'd0, o_mem_cmd_addr}, 32'h400);
        chk("rstcmd.we", {31'd0, o_mem_cmd_we}, 1);
        rst = 1;
        tick(1);
        rst = 0;
        i_wr_req = 0;
        i_rd_req = 0;
        chk("rstcmd.valid", {31'd0, o_mem_cmd_valid}, 0);
        chk("rstcmd.slots", {28'd0, o_wr_slot, o_rd_slot}, 32'h1);
        i_mem_done = 1;
        tick(1);
        i_mem_done = 0;
        tick(2);
        chk("late_done.gnt", {30'd0, o_wr_gnt, o_rd_gnt}, 0);
        chk("late_done.valid", {31'd0, o_mem_cmd_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
